// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched from an
// external key store through rk_idx/rk_data, valid/ready handshakes on both sides.
module aes_dec_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam logic [3:0] NR_M1  = 4'(NR - 1);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] r;
        t = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] st);
        logic [127:0] res;
        res = 128'h0;
        for (int i = 0; i < 16; i++) begin
            res[127-8*i -: 8] = inv_sbox(st[127-8*i -: 8]);
        end
        return res;
    endfunction

    // byte (r,c) sits at index r+4c; row r rotates right by r columns
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] st);
        logic [127:0] res;
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = st[127-32*c -: 8];
            a1 = st[119-32*c -: 8];
            a2 = st[111-32*c -: 8];
            a3 = st[103-32*c -: 8];
            res[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            res[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            res[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            res[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return res;
    endfunction

    fsm_t         fsm_r;
    logic [127:0] state_r;
    logic [3:0]   cnt_r;
    logic [3:0]   rk_idx_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;
    logic [127:0] ark_s;
    logic [127:0] mix_s;

    assign ark_s = inv_sub_bytes(inv_shift_rows(state_r)) ^ rk_data;
    assign mix_s = inv_mix_columns(ark_s);

    // Round sequencer: state, counter and all handshake outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r       <= IDLE;
            state_r     <= 128'h0;
            cnt_r       <= 4'd0;
            rk_idx_r    <= NR_IDX;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        fsm_r      <= ROUND;
                        state_r    <= in_data ^ rk_data;
                        cnt_r      <= NR_M1;
                        rk_idx_r   <= NR_M1;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ROUND: begin
                    state_r <= mix_s;
                    cnt_r   <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        fsm_r    <= FINAL;
                        rk_idx_r <= 4'd0;
                    end else begin
                        rk_idx_r <= cnt_r - 4'd1;
                    end
                end
                FINAL: begin
                    fsm_r       <= DONE;
                    state_r     <= ark_s;
                    rk_idx_r    <= 4'd0;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_r       <= IDLE;
                        rk_idx_r    <= NR_IDX;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    fsm_r       <= IDLE;
                    state_r     <= 128'h0;
                    cnt_r       <= 4'd0;
                    rk_idx_r    <= NR_IDX;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign rk_idx    = rk_idx_r;
    assign out_data  = state_r;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Self-checking bench: the reference is a forward AES-128 cipher with its own key
// expansion; the DUT must invert it, with protocol timing checked cycle by cycle.
module tb_aes_dec_round_ctrl;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk_mem [0:15];
    logic [7:0]   sbox_t [0:255];
    int           checks = 0;
    int           failures = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_IS  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

    aes_dec_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rk_idx(rk_idx), .rk_data(rk_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    assign rk_data = rk_mem[rk_idx];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rcon;
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 16; r++) rk_mem[r] = 128'h0;
        for (int r = 0; r <= NR; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Forward cipher: SubBytes, ShiftRows, MixColumns, AddRoundKey
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] v;
        v = pt ^ rk_mem[0];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[v[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            if (rnd < NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
            v = v ^ rk_mem[rnd];
        end
        return v;
    endfunction

    task automatic send(input logic [127:0] ct);
        check_eq("idle_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("idle_rk_idx", 128'(rk_idx), 128'(NR));
        in_valid = 1'b1;
        in_data  = ct;
        tick();
        in_valid = 1'b0;
    endtask

    // Runs from the cycle after acceptance until out_valid, bounded
    task automatic run_to_done(input bit rnd);
        int         edges;
        int         busy_n;
        int         inr_n;
        logic [3:0] rk_q [$];
        edges = 0; busy_n = 0; inr_n = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            rk_q.push_back(rk_idx);
            if (busy === 1'b1) busy_n++;
            if (in_ready !== 1'b0) inr_n++;
            if (rnd) begin
                out_ready = 1'($urandom);
                in_valid  = 1'($urandom);
                in_data   = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            edges++;
        end
        if (rnd) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
        check_eq("latency", 128'(edges), 128'(NR));
        check_eq("busy_cycles", 128'(busy_n), 128'(NR));
        check_eq("in_ready_while_busy", 128'(inr_n), 128'(0));
        check_eq("done_busy", 128'(busy), 128'(1'b0));
        check_eq("rk_seq_len", 128'(rk_q.size()), 128'(NR));
        for (int i = 0; i < rk_q.size() && i < NR; i++)
            check_eq("rk_seq", 128'(rk_q[i]), 128'((i < NR - 1) ? NR - 1 - i : 0));
    endtask

    task automatic finish_block(input int hold, input logic [127:0] exp);
        for (int h = 0; h < hold; h++) begin
            check_eq("hold_out_valid", 128'(out_valid), 128'(1'b1));
            check_eq("hold_out_data", out_data, exp);
            check_eq("hold_in_ready", 128'(in_ready), 128'(1'b0));
            tick();
        end
        check_eq("out_valid", 128'(out_valid), 128'(1'b1));
        check_eq("plaintext", out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_hs_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("post_hs_out_valid", 128'(out_valid), 128'(1'b0));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(1'b0));
        check_eq({tag, "_out_data"}, out_data, 128'h0);
        check_eq({tag, "_rk_idx"}, 128'(rk_idx), 128'(NR));
    endtask

    initial begin
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] pt_b;
        logic [127:0] ct_b;
        rst = 1'b1; in_valid = 1'b0; in_data = 128'h0; out_ready = 1'b0;
        build_sbox();
        expand_key(C1_KEY);
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");

        // FIPS-197 C.1 with 5 cycles of output backpressure
        send(C1_CT);
        check_eq("c1_istart", out_data, C1_IS);
        check_eq("c1_istart_model", out_data, C1_CT ^ rk_mem[NR]);
        run_to_done(1'b0);
        finish_block(5, C1_PT);

        // second block offered while busy must wait for the output handshake
        pt_b = {$urandom, $urandom, $urandom, $urandom};
        ct_b = encrypt(pt_b);
        send(C1_CT);
        in_valid = 1'b1;
        in_data  = ct_b;
        run_to_done(1'b0);
        finish_block(2, C1_PT);
        send(ct_b);
        run_to_done(1'b0);
        finish_block(0, pt_b);

        // reset at round counter 5
        send(C1_CT);
        tick(); tick(); tick(); tick();
        check_eq("mid_rk_idx", 128'(rk_idx), 128'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("mid_reset");
        send(C1_CT);
        run_to_done(1'b0);
        finish_block(0, C1_PT);

        // reset wins over an output handshake in DONE
        send(C1_CT);
        run_to_done(1'b0);
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = C1_CT;
        tick();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        check_reset_state("done_reset");

        // back-to-back with out_ready tied high
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            send(C1_CT);
            run_to_done(1'b0);
            check_eq("b2b_plaintext", out_data, C1_PT);
            check_eq("b2b_done_in_ready", 128'(in_ready), 128'(1'b0));
            tick();
            check_eq("b2b_gap_in_ready", 128'(in_ready), 128'(1'b1));
            check_eq("b2b_gap_out_valid", 128'(out_valid), 128'(1'b0));
        end
        out_ready = 1'b0;

        // random keys and plaintexts, noise on ignored inputs, random backpressure
        for (int n = 0; n < 10; n++) begin
            expand_key({$urandom, $urandom, $urandom, $urandom});
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = encrypt(pt);
            send(ct);
            check_eq("rnd_istart", out_data, ct ^ rk_mem[NR]);
            run_to_done(1'b1);
            finish_block(int'($urandom_range(0, 3)), pt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_dec_round_ctrl.md
AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of cipher rounds; legal values are 10, 12 and 14 only.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all sequential logic.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  ciphertext block is offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a ciphertext.
REQ-006 SHALL have port in_data  input  128  ciphertext, byte 0 in bits [127:120], column-major AES state order.
REQ-007 SHALL have port rk_idx  output  4  index of the round key currently requested.
REQ-008 SHALL have port rk_data  input  128  round key rk_idx, supplied combinationally in the same cycle by an external key store.
REQ-009 SHALL have port out_valid  output  1  plaintext is available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the plaintext.
REQ-011 SHALL have port out_data  output  128  state register, which holds the plaintext when out_valid=1.
REQ-012 SHALL have port busy  output  1  high in ROUND and FINAL.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, FINAL and DONE, with one AES round computed per clock cycle.
REQ-014 SHALL instantiate combinational InvShiftRows, InvSubBytes, InvMixColumns and AddRoundKey stages; no other stage may be pipelined.
REQ-015 SHALL drive in_ready=1 only in IDLE; acceptance occurs on an edge where in_valid=1 and in_ready=1.
REQ-016 SHALL drive rk_idx as follows: IDLE uses NR; ROUND uses the round counter; FINAL uses 0; DONE uses 0.
REQ-017 SHALL, on the accept edge, load state <= in_data XOR rk_data, load round counter <= NR-1, and move to ROUND.
REQ-018 SHALL, in ROUND, update state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data)) on each edge and decrement the counter.
REQ-019 SHALL move from ROUND to FINAL on the edge where the counter equals 1.
REQ-020 SHALL, in FINAL, update state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data) and move to DONE.
REQ-021 SHALL make out_valid rise exactly NR rising edges after the accept edge; it SHALL be 1 only in DONE.
REQ-022 SHALL hold out_valid and out_data stable in DONE until out_ready=1; the handshake edge returns the FSM to IDLE.
REQ-023 SHALL raise in_ready in the cycle after the output handshake; no same-cycle bypass of input acceptance is permitted.
REQ-024 SHALL ignore in_valid while busy or in DONE; in_data is not sampled in those states.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL keep state and counter unchanged while in IDLE with no acceptance, or while in DONE.
REQ-027 SHALL limit the round counter to 4 bits; it SHALL never wrap below 1 in ROUND.

Reset
REQ-028 SHALL, when rst=1 at an edge, force the FSM to IDLE, state to 0 and the counter to 0, regardless of the current state, including mid-round and DONE.
REQ-029 SHALL produce these values in the cycle after reset: in_ready=1, out_valid=0, busy=0, out_data=0, rk_idx=NR.
REQ-030 SHALL give rst priority over any simultaneous in_valid or out_ready handshake; the block in flight is discarded.

Verification
REQ-031 SHALL pass the FIPS-197 C.1 round-trip check: NR=10, bench key store holds the round keys of key 000102030405060708090a0b0c0d0e0f, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> after the accept edge out_data=7ad5fda789ef4e272bca100b3d9ff59f; 10 edges later out_valid=1 with out_data=00112233445566778899aabbccddeeff.
REQ-032 SHALL pass the rk_idx sequence check: one block accepted -> rk_idx reads 10 in IDLE, 9,8,...,1 in ROUND, then 0 in FINAL, with busy=1 for exactly 10 cycles.
REQ-033 SHALL pass the backpressure check: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data are held constant and in_ready=0 throughout; out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
REQ-034 SHALL pass the busy-input check: in_valid=1 with a second ciphertext during ROUND -> no acceptance; the first result is unchanged, and the second block is accepted only after the output handshake.
REQ-035 SHALL pass the reset-mid-operation check: rst=1 at round counter 5 -> next cycle IDLE, out_data=0, out_valid=0; the next C.1 block decrypts correctly.
REQ-036 SHALL pass the back-to-back check: two C.1 blocks with out_ready tied to 1 -> a 1-cycle IDLE gap, and both outputs equal 00112233445566778899aabbccddeeff.
